// File: rtl/i2s_sample_fifo.sv
// Sample FIFO feeding the WM8731 serial sender: valid/ready push side, ren-edge pop side.
// Define I2S_FIFO_UNDERRUN_MUTE_EN to output silence on underrun instead of repeating the last word.
module i2s_sample_fifo #(
    parameter int DATA_W     = 24,
    parameter int DEPTH_LOG2 = 4,
    parameter int UCNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  ren,
    output logic [DATA_W-1:0]     sample_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic [UCNT_W-1:0]     underrun_cnt,
    input  logic                  underrun_clr
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [UCNT_W-1:0]     UCNT_ONE = UCNT_W'(1);
    localparam logic [UCNT_W-1:0]     UCNT_MAX = '1;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [DATA_W-1:0]     r_sample;
    logic [UCNT_W-1:0]     r_ucnt;
    logic                  r_ren_d;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop_evt;
    logic                  w_pop_ok;
    logic                  w_underrun;
    logic [DEPTH_LOG2:0]   w_level_nxt;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LVL_FULL);
    assign w_push     = wr_valid && !w_full;
    // The sender holds ren high for many cycles; only its rising edge is a pop request.
    assign w_pop_evt  = ren && !r_ren_d;
    assign w_pop_ok   = w_pop_evt && !w_empty;
    assign w_underrun = w_pop_evt && w_empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop_ok})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // NOTE: storage has no reset; entries are only read after being written, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ren_d <= 1'b0;
        end else begin
            r_ren_d <= ren;
            r_level <= w_level_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample <= '0;
        end else if (w_pop_ok) begin
            r_sample <= r_mem[r_rptr];
`ifdef I2S_FIFO_UNDERRUN_MUTE_EN
        end else if (w_underrun) begin
            r_sample <= '0;
`endif
        end
    end

    // Clear wins over a coincident underrun; the count sticks at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ucnt <= '0;
        end else if (underrun_clr) begin
            r_ucnt <= '0;
        end else if (w_underrun && (r_ucnt != UCNT_MAX)) begin
            r_ucnt <= r_ucnt + UCNT_ONE;
        end
    end

    assign wr_ready     = !w_full;
    assign sample_data  = r_sample;
    assign level        = r_level;
    assign empty        = w_empty;
    assign full         = w_full;
    assign underrun_cnt = r_ucnt;

    a_level_bound: assert property (@(posedge clk) disable iff (!rst) r_level <= LVL_FULL);
    a_not_both:    assert property (@(posedge clk) disable iff (!rst) !(w_empty && w_full));
    a_ptr_level:   assert property (@(posedge clk) disable iff (!rst)
                       (r_wptr - r_rptr) == r_level[DEPTH_LOG2-1:0]);

endmodule
